// File: rtl/serial_pkg.sv
// Shared types and constants for the serial frame receiver.
//   state_e              : receiver FSM state (HUNT searches for sync, RECV collects payload)
//   DEFAULT_SYNC_PATTERN : default 6-bit sync word, leftmost bit received first
package serial_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_e;

  localparam logic [5:0] DEFAULT_SYNC_PATTERN = 6'b011010;

endpackage

// File: rtl/sync_detector.sv
// Sliding-window sync word detector.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bit_i         : serial bit
//   valid_i       : bit_i is a qualified bit to be searched (only asserted while hunting)
//   clear_i       : empty the history and fill count (frame finished)
//   match_o       : combinational; this qualified bit completes the sync word
module sync_detector
  import serial_pkg::*;
#(
  parameter int unsigned         SYNC_LEN     = 6,
  parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = DEFAULT_SYNC_PATTERN
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic bit_i,
  input  logic valid_i,
  input  logic clear_i,
  output logic match_o
);

  localparam int unsigned FillW = $clog2(SYNC_LEN + 1);

  // Only the newest SYNC_LEN-1 bits are kept: the oldest bit of the window would
  // always be shifted out before it could take part in a compare.
  logic [SYNC_LEN-2:0] hist_q, hist_d;
  logic [FillW-1:0]    fill_q, fill_d;
  logic [SYNC_LEN-1:0] window;

  // The candidate window always includes the incoming bit, so any suffix of a
  // failed partial match is still present for the next compare.
  assign window  = {hist_q, bit_i};
  assign match_o = valid_i && (fill_q >= FillW'(SYNC_LEN - 1)) && (window == SYNC_PATTERN);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (valid_i) begin
      hist_d = window[SYNC_LEN-2:0];
      if (fill_q != FillW'(SYNC_LEN)) begin
        fill_d = fill_q + FillW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for a sync word, then captures a fixed-length payload.
//   clk, rst_n  : clock, asynchronous active-low reset
//   serData     : serial line bit
//   serValid    : qualifies serData; unqualified cycles stall everything
//   outValid    : high while receiving a payload
//   dataOut     : last completed payload, first-received bit at MSB
//   frameDone   : one-cycle pulse when dataOut is updated
//   frameCount  : completed frames, wrapping
module serial_frame_rx
  import serial_pkg::*;
#(
  parameter int unsigned         SYNC_LEN     = 6,
  parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = DEFAULT_SYNC_PATTERN,
  parameter int unsigned         PAYLOAD_LEN  = 32,
  parameter int unsigned         CNT_W        = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   serData,
  input  logic                   serValid,
  output logic                   outValid,
  output logic [PAYLOAD_LEN-1:0] dataOut,
  output logic                   frameDone,
  output logic [CNT_W-1:0]       frameCount
);

  // Counts 0..PAYLOAD_LEN-1; a width of at least 1 keeps PAYLOAD_LEN=1 legal.
  localparam int unsigned BitCntW = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;

  state_e                 state_q, state_d;
  logic [BitCntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [PAYLOAD_LEN-1:0] shift_q, shift_d;
  logic [PAYLOAD_LEN-1:0] data_q, data_d;
  logic                   done_q, done_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   hunt_valid;
  logic                   last_bit;
  logic                   match;
  logic [PAYLOAD_LEN-1:0] shift_next;

  assign hunt_valid = serValid && (state_q == HUNT);
  assign last_bit   = serValid && (state_q == RECV) &&
                      (bit_cnt_q == BitCntW'(PAYLOAD_LEN - 1));
  assign shift_next = (shift_q << 1) | PAYLOAD_LEN'(serData);

  sync_detector #(
    .SYNC_LEN     (SYNC_LEN),
    .SYNC_PATTERN (SYNC_PATTERN)
  ) u_sync_detector (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .bit_i   (serData),
    .valid_i (hunt_valid),
    .clear_i (last_bit),
    .match_o (match)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    unique case (state_q)
      HUNT: begin
        if (match) begin
          state_d   = RECV;
          bit_cnt_d = '0;
        end
      end
      RECV: begin
        if (serValid) begin
          shift_d   = shift_next;
          bit_cnt_d = bit_cnt_q + BitCntW'(1);
          if (last_bit) begin
            // Publish the whole word at once so dataOut never shows a partial shift.
            data_d    = shift_next;
            done_d    = 1'b1;
            cnt_d     = cnt_q + CNT_W'(1);
            bit_cnt_d = '0;
            state_d   = HUNT;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
    end
  end

  assign outValid   = (state_q == RECV);
  assign dataOut    = data_q;
  assign frameDone  = done_q;
  assign frameCount = cnt_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
module tb_serial_frame_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        d0, v0, d1, v1;
  logic        ov0, fd0, ov1, fd1;
  logic [31:0] do0;
  logic [7:0]  fc0;
  logic [7:0]  do1;
  logic [1:0]  fc1;

  int n_total = 0;
  int n_bad   = 0;

  serial_frame_rx u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .serData    (d0),
    .serValid   (v0),
    .outValid   (ov0),
    .dataOut    (do0),
    .frameDone  (fd0),
    .frameCount (fc0)
  );

  serial_frame_rx #(
    .SYNC_LEN     (4),
    .SYNC_PATTERN (4'b1011),
    .PAYLOAD_LEN  (8),
    .CNT_W        (2)
  ) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .serData    (d1),
    .serValid   (v1),
    .outValid   (ov1),
    .dataOut    (do1),
    .frameDone  (fd1),
    .frameCount (fc1)
  );

  // Reference model: bit-stream view. Hunting = "do the last SYNC_LEN qualified bits
  // since the last frame equal the pattern"; receiving = "collect PAYLOAD_LEN bits".
  int          m_sl[2];
  logic [63:0] m_pat[2];
  int          m_pl[2];
  int          m_cw[2];
  bit          m_recv[2];
  logic [63:0] m_hist[2];
  int          m_hist_n[2];
  logic [63:0] m_pay[2];
  int          m_pay_n[2];
  logic [63:0] m_data[2];
  bit          m_done[2];
  int unsigned m_cnt[2];
  int          ov_seen[2];
  int          done_seen[2];
  int          stall_step;

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_recv[k]   = 1'b0;
      m_hist[k]   = '0;
      m_hist_n[k] = 0;
      m_pay[k]    = '0;
      m_pay_n[k]  = 0;
      m_data[k]   = '0;
      m_done[k]   = 1'b0;
      m_cnt[k]    = 0;
    end
  endfunction

  function automatic void model_step(int k, logic d, logic v);
    logic [63:0] mask;
    m_done[k] = 1'b0;
    if (!v) return;
    if (!m_recv[k]) begin
      m_hist[k] = {m_hist[k][62:0], d};
      m_hist_n[k]++;
      mask = (64'd1 << m_sl[k]) - 64'd1;
      if (m_hist_n[k] >= m_sl[k] && (m_hist[k] & mask) == m_pat[k]) begin
        m_recv[k]  = 1'b1;
        m_pay[k]   = '0;
        m_pay_n[k] = 0;
      end
    end else begin
      m_pay[k] = {m_pay[k][62:0], d};
      m_pay_n[k]++;
      if (m_pay_n[k] == m_pl[k]) begin
        m_data[k]   = m_pay[k];
        m_done[k]   = 1'b1;
        m_cnt[k]    = (m_cnt[k] + 1) % (32'd1 << m_cw[k]);
        m_recv[k]   = 1'b0;
        m_hist[k]   = '0;
        m_hist_n[k] = 0;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("ov_a",   64'(ov0), 64'(m_recv[0]));
    check("done_a", 64'(fd0), 64'(m_done[0]));
    check("data_a", 64'(do0), m_data[0]);
    check("cnt_a",  64'(fc0), 64'(m_cnt[0]));
    check("ov_b",   64'(ov1), 64'(m_recv[1]));
    check("done_b", 64'(fd1), 64'(m_done[1]));
    check("data_b", 64'(do1), m_data[1]);
    check("cnt_b",  64'(fc1), 64'(m_cnt[1]));
  endtask

  task automatic tick(input logic a0, input logic b0, input logic a1, input logic b1);
    d0 = a0; v0 = b0; d1 = a1; v1 = b1;
    @(posedge clk);
    #1;
    model_step(0, a0, b0);
    model_step(1, a1, b1);
    if (ov0) ov_seen[0]++;
    if (fd0) done_seen[0]++;
    if (ov1) ov_seen[1]++;
    if (fd1) done_seen[1]++;
    check_outputs();
  endtask

  // MSB-first; stall > 0 inserts an unqualified cycle every stall-th cycle.
  task automatic send0(input logic [63:0] val, input int n, input int stall);
    for (int i = n - 1; i >= 0; i--) begin
      if (stall > 0) begin
        stall_step++;
        if (stall_step % stall == 0) begin
          tick(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
          stall_step++;
        end
      end
      tick(val[i], 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic send1(input logic [63:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) tick(1'b0, 1'b0, val[i], 1'b1);
  endtask

  task automatic clear_seen();
    for (int k = 0; k < 2; k++) begin
      ov_seen[k]   = 0;
      done_seen[k] = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_seen();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pay;
    logic [7:0]  byt;
    int          r;
    m_sl[0] = 6; m_pat[0] = 64'b011010; m_pl[0] = 32; m_cw[0] = 8;
    m_sl[1] = 4; m_pat[1] = 64'b1011;   m_pl[1] = 8;  m_cw[1] = 2;
    stall_step = 0;
    rst_n = 1'b0;
    d0 = 1'b0; v0 = 1'b0; d1 = 1'b0; v1 = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    check("reset_data_a", 64'(do0), 64'd0);
    check("reset_cnt_a", 64'(fc0), 64'd0);
    rst_n = 1'b1;
    clear_seen();

    // Basic frame
    send0(64'b011010, 6, 0);
    send0(64'hDEADBEEF, 32, 0);
    check("t1_ov_cycles", 64'(ov_seen[0]), 64'd32);
    check("t1_done_cnt", 64'(done_seen[0]), 64'd1);
    check("t1_data", 64'(do0), 64'hDEADBEEF);
    check("t1_count", 64'(fc0), 64'd1);
    repeat (3) tick(1'b0, 1'b1, 1'b0, 1'b0);

    // Overlapping sync: 011011010 matches only on the ninth bit
    do_reset();
    pay = $urandom();
    send0(64'b01101101, 8, 0);
    check("t2_no_early_sync", 64'(ov0), 64'd0);
    send0(64'b0, 1, 0);
    check("t2_sync_bit9", 64'(ov0), 64'd1);
    send0(64'(pay), 32, 0);
    check("t2_data", 64'(do0), 64'(pay));
    check("t2_count", 64'(fc0), 64'd1);

    // Stalls every third cycle
    do_reset();
    send0(64'b011010, 6, 3);
    send0(64'hDEADBEEF, 32, 3);
    check("t3_data", 64'(do0), 64'hDEADBEEF);
    check("t3_done_cnt", 64'(done_seen[0]), 64'd1);
    check("t3_count", 64'(fc0), 64'd1);

    // Payload containing the sync word, then a second frame back to back
    do_reset();
    pay = $urandom();
    send0(64'b011010, 6, 0);
    send0(64'h011A011A, 32, 0);
    check("t4_data1", 64'(do0), 64'h011A011A);
    check("t4_ov_after1", 64'(ov0), 64'd0);
    send0(64'b011010, 6, 0);
    send0(64'(pay), 32, 0);
    check("t4_data2", 64'(do0), 64'(pay));
    check("t4_done_cnt", 64'(done_seen[0]), 64'd2);
    check("t4_count", 64'(fc0), 64'd2);

    // Reset in the middle of a frame
    do_reset();
    send0(64'b011010, 6, 0);
    send0(64'h12345678, 32, 0);
    pay = $urandom();
    send0(64'b011010, 6, 0);
    send0(64'(pay >> 22), 10, 0);
    rst_n = 1'b0;
    #1;
    check("t5_rst_ov", 64'(ov0), 64'd0);
    check("t5_rst_data", 64'(do0), 64'd0);
    check("t5_rst_done", 64'(fd0), 64'd0);
    check("t5_rst_count", 64'(fc0), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send0(64'b011010, 6, 0);
    send0(64'(pay), 32, 0);
    check("t5_data", 64'(do0), 64'(pay));
    check("t5_count", 64'(fc0), 64'd1);

    // Small configuration: five frames, 2-bit counter wraps
    do_reset();
    for (int f = 0; f < 5; f++) begin
      byt = 8'($urandom_range(0, 255));
      send1(64'b1011, 4);
      send1(64'(byt), 8);
      check("t6_byte", 64'(do1), 64'(byt));
    end
    check("t6_count_wrap", 64'(fc1), 64'd1);
    check("t6_done_cnt", 64'(done_seen[1]), 64'd5);

    // Random traffic on both receivers, with occasional injected sync words
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 24));
      if (r == 0) begin
        send0(64'b011010, 6, 0);
      end else if (r == 1) begin
        send1(64'b1011, 4);
      end else begin
        tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      end
    end
    check("rand_frames_a", 64'(done_seen[0] > 0), 64'd1);
    check("rand_frames_b", 64'(done_seen[1] > 0), 64'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
